warp_mem_responder: RTL and testbench

//   Memory-side responder for the warp_engine mem_req/mem_resp interface: a word-addressed SRAM that

---
 rtl/warp_mem_responder.sv | 141 ++++++++++++++
 tb/tb_warp_mem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_mem_responder.sv
// Word-addressed SRAM responder for warp_engine with fixed read latency
// and a credit-gated in-order response FIFO.
module warp_mem_responder #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MEM_WORDS       = 1024,
   parameter int READ_LATENCY    = 2,
   parameter int RESP_FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mem_req_valid,
   output logic                         mem_req_ready,
   input  logic [ADDR_WIDTH-1:0]        mem_req_addr,
   input  logic                         mem_req_write,
   input  logic [DATA_WIDTH-1:0]        mem_req_data,
   output logic                         mem_resp_valid,
   input  logic                         mem_resp_ready,
   output logic [DATA_WIDTH-1:0]        mem_resp_data,
   output logic                         mem_resp_err,
   input  logic                         init_we,
   input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
   input  logic [DATA_WIDTH-1:0]        init_data,
   output logic [15:0]                  stat_reads,
   output logic [15:0]                  stat_writes
);
   localparam int IW = $clog2(MEM_WORDS);
   localparam int PD = READ_LATENCY - 1;
   localparam int PS = (PD > 0) ? PD : 1;
   localparam int FW = $clog2(RESP_FIFO_DEPTH);
   localparam int CW = $clog2(RESP_FIFO_DEPTH + READ_LATENCY) + 1;

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic [IW-1:0]         widx;
   logic                  bad;
   logic                  acc, rd_acc, wr_acc;
   logic [DATA_WIDTH-1:0] rd_data;

   logic [PS-1:0]         pv_q, pe_q;
   logic [DATA_WIDTH-1:0] pd_q [PS];

   logic                  push_v, push_e, pop;
   logic [DATA_WIDTH-1:0] push_d;

   logic [DATA_WIDTH-1:0]      fd_q [RESP_FIFO_DEPTH];
   logic [RESP_FIFO_DEPTH-1:0] fe_q;
   logic [FW-1:0]              wp_q, rp_q;
   logic [CW-1:0]              cnt_q, cnt_d, inflight;
   logic [15:0]                rd_cnt_q, wr_cnt_q;

   assign widx = mem_req_addr[IW+1:2];
   assign bad  = (mem_req_addr[1:0] != 2'b00) ||
                 (|mem_req_addr[ADDR_WIDTH-1:IW+2]);

   // Credits count every outstanding read, so the pipe can never stall.
   assign inflight = (PD == 0) ? '0 : CW'($countones(pv_q));
   assign mem_req_ready = !rst && !init_we &&
                          ((cnt_q + inflight) < CW'(RESP_FIFO_DEPTH));

   assign acc     = mem_req_valid && mem_req_ready;
   assign rd_acc  = acc && !mem_req_write;
   assign wr_acc  = acc && mem_req_write;
   assign rd_data = bad ? '0 : mem_q[widx];

   always_ff @(posedge clk) begin
      if (init_we) begin
         mem_q[init_addr] <= init_data;
      end else if (wr_acc && !bad) begin
         mem_q[widx] <= mem_req_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv_q <= '0;
         pe_q <= '0;
         for (int k = 0; k < PS; k++) pd_q[k] <= '0;
      end else begin
         pv_q[0] <= rd_acc;
         pe_q[0] <= bad;
         pd_q[0] <= rd_data;
         for (int k = 1; k < PS; k++) begin
            pv_q[k] <= pv_q[k-1];
            pe_q[k] <= pe_q[k-1];
            pd_q[k] <= pd_q[k-1];
         end
      end
   end

   assign push_v = (PD == 0) ? rd_acc  : pv_q[PS-1];
   assign push_e = (PD == 0) ? bad     : pe_q[PS-1];
   assign push_d = (PD == 0) ? rd_data : pd_q[PS-1];

   assign mem_resp_valid = (cnt_q != '0);
   assign pop            = mem_resp_valid && mem_resp_ready;
   assign mem_resp_data  = mem_resp_valid ? fd_q[rp_q] : '0;
   assign mem_resp_err   = mem_resp_valid && fe_q[rp_q];

   always_comb begin
      cnt_d = cnt_q;
      if (push_v && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push_v) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_v) begin
         fd_q[wp_q] <= push_d;
         fe_q[wp_q] <= push_e;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q     <= '0;
         rp_q     <= '0;
         cnt_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (push_v) wp_q <= wp_q + FW'(1);
         if (pop) rp_q <= rp_q + FW'(1);
         cnt_q <= cnt_d;
         if (rd_acc) rd_cnt_q <= rd_cnt_q + 16'd1;
         if (wr_acc) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push_v && cnt_q == CW'(RESP_FIFO_DEPTH)));
      end
   end

   assign stat_reads  = rd_cnt_q;
   assign stat_writes = wr_cnt_q;

endmodule

// File: tb/tb_warp_mem_responder.sv
// Randomized bench for warp_mem_responder against a queue-based
// model of outstanding responses plus directed literal checks.
module tb_warp_mem_responder;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int MW    = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req_valid, mem_req_ready, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_data;
   logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
   logic [31:0] mem_resp_data;
   logic        init_we;
   logic [9:0]  init_addr;
   logic [31:0] init_data;
   logic [15:0] stat_reads, stat_writes;

   always #5 clk = ~clk;

   warp_mem_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MW),
      .READ_LATENCY(LAT), .RESP_FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
      .mem_req_data(mem_req_data),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .stat_reads(stat_reads), .stat_writes(stat_writes)
   );

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          t;
   } rsp_t;

   rsp_t        q[$];
   logic [31:0] mdl_mem [MW];
   logic [15:0] n_rd, n_wr;
   int          edge_n = 0;
   int          vec = 0;
   int          mis = 0;
   bit          last_acc;
   int          pops;

   task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
      vec++;
      if (got !== exp) begin
         mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic bit bad_of(logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'd4096);
   endfunction

   task automatic set_req(bit v, bit w, logic [31:0] a, logic [31:0] d);
      mem_req_valid = v;
      mem_req_write = w;
      mem_req_addr  = a;
      mem_req_data  = d;
   endtask

   // One clock: compare outputs to the model, then advance the model.
   task automatic step();
      bit   mready, mvalid, acc, pop, b;
      rsp_t r;
      #1;
      mready = !rst && !init_we && (q.size() < DEPTH);
      mvalid = (q.size() > 0) && (edge_n >= q[0].t + LAT);
      check("req_ready", 64'(mem_req_ready), 64'(mready));
      check("resp_valid", 64'(mem_resp_valid), 64'(mvalid));
      if (mvalid) begin
         check("resp_data", 64'(mem_resp_data), 64'(q[0].d));
         check("resp_err", 64'(mem_resp_err), 64'(q[0].e));
      end
      check("stat_reads", 64'(stat_reads), 64'(n_rd));
      check("stat_writes", 64'(stat_writes), 64'(n_wr));
      acc = mem_req_valid && mready;
      pop = mvalid && mem_resp_ready;
      last_acc = acc;
      if (pop) pops++;
      b = bad_of(mem_req_addr);
      @(posedge clk);
      if (!rst) begin
         if (pop) void'(q.pop_front());
         if (init_we) mdl_mem[init_addr] = init_data;
         if (acc && mem_req_write) begin
            n_wr++;
            if (!b) mdl_mem[mem_req_addr[11:2]] = mem_req_data;
         end else if (acc) begin
            n_rd++;
            r.d = b ? 32'd0 : mdl_mem[mem_req_addr[11:2]];
            r.e = b;
            r.t = edge_n;
            q.push_back(r);
         end
      end
      edge_n++;
      @(negedge clk);
   endtask

   task automatic do_reset(int n);
      rst = 1'b1;
      q.delete();
      n_rd = '0;
      n_wr = '0;
      #1;
      check("rst_ready", 64'(mem_req_ready), 64'd0);
      check("rst_valid", 64'(mem_resp_valid), 64'd0);
      check("rst_data", 64'(mem_resp_data), 64'd0);
      check("rst_err", 64'(mem_resp_err), 64'd0);
      check("rst_stats", {32'd0, stat_reads, stat_writes}, 64'd0);
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int acc_cnt;
      set_req(0, 0, 0, 0);
      mem_resp_ready = 1'b1;
      init_we = 1'b0;
      init_addr = '0;
      init_data = '0;
      n_rd = '0;
      n_wr = '0;
      @(negedge clk);

      // 1: reset and idle
      do_reset(3);
      #1;
      check("t1_ready", 64'(mem_req_ready), 64'd1);
      check("t1_valid", 64'(mem_resp_valid), 64'd0);
      step();

      // 2: preload then read word 0
      for (int i = 0; i < 16; i++) begin
         init_we = 1'b1;
         init_addr = 10'(i);
         init_data = 32'h000A_0000 + 32'(i) * 32'h1_0000;
         step();
      end
      init_we = 1'b0;
      set_req(1, 0, 32'h0, 0);
      step();
      check("t2_acc", 64'(last_acc), 64'd1);
      check("t2_lat1_valid", 64'(mem_resp_valid), 64'd0);
      set_req(0, 0, 0, 0);
      step();
      check("t2_valid", 64'(mem_resp_valid), 64'd1);
      check("t2_data", 64'(mem_resp_data), 64'h000A_0000);
      check("t2_err", 64'(mem_resp_err), 64'd0);
      repeat (2) step();

      // 3: read-after-write
      do_reset(2);
      set_req(1, 1, 32'h10, 32'hDEAD_BEEF);
      step();
      set_req(1, 0, 32'h10, 0);
      step();
      set_req(0, 0, 0, 0);
      step();
      check("t3_valid", 64'(mem_resp_valid), 64'd1);
      check("t3_data", 64'(mem_resp_data), 64'hDEAD_BEEF);
      check("t3_wr", 64'(stat_writes), 64'd1);
      check("t3_rd", 64'(stat_reads), 64'd1);
      repeat (2) step();

      // 4: backpressure
      mem_resp_ready = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         set_req(1, 0, 32'(i) * 4, 0);
         step();
         acc_cnt += int'(last_acc);
      end
      check("t4_accepts", 64'(acc_cnt), 64'd4);
      check("t4_ready_low", 64'(mem_req_ready), 64'd0);
      set_req(0, 0, 0, 0);
      mem_resp_ready = 1'b1;
      pops = 0;
      repeat (6) step();
      check("t4_pops", 64'(pops), 64'd4);
      set_req(1, 0, 32'h8, 0);
      step();
      check("t4_resume", 64'(last_acc), 64'd1);
      set_req(0, 0, 0, 0);
      repeat (3) step();

      // 5: bad addresses
      set_req(1, 0, 32'h1002, 0);
      step();
      set_req(1, 0, 32'h1000, 0);
      step();
      check("t5_valid0", 64'(mem_resp_valid), 64'd1);
      check("t5_data0", 64'(mem_resp_data), 64'd0);
      check("t5_err0", 64'(mem_resp_err), 64'd1);
      set_req(1, 1, 32'h1000, 32'h1234_5678);
      step();
      check("t5_err1", 64'(mem_resp_err), 64'd1);
      check("t5_wr", 64'(stat_writes), 64'd2);
      set_req(1, 0, 32'h0, 0);
      step();
      set_req(0, 0, 0, 0);
      step();
      check("t5_unchanged", 64'(mem_resp_data), 64'h000A_0000);
      repeat (2) step();

      // 6: reset with reads in flight
      mem_resp_ready = 1'b0;
      set_req(1, 0, 32'h8, 0);
      step();
      set_req(1, 0, 32'hC, 0);
      step();
      set_req(1, 0, 32'h14, 0);
      step();
      set_req(0, 0, 0, 0);
      do_reset(2);
      mem_resp_ready = 1'b1;
      repeat (4) step();
      check("t6_no_resp", 64'(mem_resp_valid), 64'd0);
      set_req(1, 0, 32'h4, 0);
      step();
      set_req(0, 0, 0, 0);
      step();
      check("t6_data", 64'(mem_resp_data), 64'h000B_0000);
      step();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         int          sel;
         logic [31:0] a;
         sel = int'($urandom_range(0, 7));
         if (sel <= 5) a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         else if (sel == 6) a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
         else a = 32'h1000 + ($urandom & 32'h00FF_FFFC);
         set_req($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, $urandom);
         mem_resp_ready = ($urandom_range(0, 3) != 0);
         init_we = ($urandom_range(0, 15) == 0);
         init_addr = 10'($urandom_range(0, 15));
         init_data = $urandom;
         if ($urandom_range(0, 399) == 0) begin
            init_we = 1'b0;
            do_reset(int'($urandom_range(1, 3)));
         end
         step();
      end
      set_req(0, 0, 0, 0);
      init_we = 1'b0;
      mem_resp_ready = 1'b1;
      repeat (10) step();
      check("drain_empty", 64'(mem_resp_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end
endmodule
